// File: rtl/unidade_controle_param.sv
// Multicycle MIPS control unit with memory wait states,
// mult/div start/done handshake and vectored exceptions.
module unidade_controle_param #(
  parameter int MEM_WAIT   = 1,
  parameter int VEC_OPCODE = 253,
  parameter int VEC_OVF    = 254,
  parameter int VEC_DIV0   = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  input  logic       md_done,
  input  logic       md_div0,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic [1:0] iord,
  output logic [7:0] exc_vec,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_source,
  output logic       epc_write,
  output logic       md_start,
  output logic       md_op,
  output logic       hilo_write,
  output logic [1:0] exc_cause,
  output logic [5:0] estado_saida
);

  typedef enum logic [5:0] {
    S_RESET    = 6'd0,
    S_FETCH    = 6'd1,
    S_FETCH_W  = 6'd2,
    S_DECODE   = 6'd3,
    S_EXEC_R   = 6'd4,
    S_WB_R     = 6'd5,
    S_EXEC_I   = 6'd6,
    S_WB_I     = 6'd7,
    S_MEM_ADDR = 6'd8,
    S_MEM_RD   = 6'd9,
    S_MEM_WB   = 6'd10,
    S_MEM_WR   = 6'd11,
    S_BRANCH   = 6'd12,
    S_JUMP     = 6'd13,
    S_MD_START = 6'd14,
    S_MD_WAIT  = 6'd15,
    S_MF_WB    = 6'd16,
    S_EXC_EPC  = 6'd17,
    S_EXC_RD   = 6'd18,
    S_EXC_LOAD = 6'd19,
    S_HALT     = 6'd20
  } state_t;

  localparam int CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [CW-1:0] WAIT_LD = CW'(MEM_WAIT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    cause_q, cause_d;

  // ALU flag zero only gates the PC in the datapath
  logic unused_zero;
  assign unused_zero = zero;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
      cause_q <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cause_d       = cause_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    iord          = 2'b00;
    exc_vec       = 8'd0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 3'b000;
    pc_source     = 2'b00;
    epc_write     = 1'b0;
    md_start      = 1'b0;
    md_op         = 1'b0;
    hilo_write    = 1'b0;
    unique case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        cnt_d   = WAIT_LD;
        state_d = S_FETCH_W;
      end
      S_FETCH_W: begin
        if (cnt_q == '0) begin
          ir_write  = 1'b1;
          alu_src_b = 2'b01;
          pc_write  = 1'b1;
          state_d   = S_DECODE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        if (opcode == 6'h00) begin
          unique case (funct)
            6'h20, 6'h22, 6'h24, 6'h2a: state_d = S_EXEC_R;
            6'h18, 6'h1a:               state_d = S_MD_START;
            6'h10, 6'h12:               state_d = S_MF_WB;
            6'h0d:                      state_d = S_HALT;
            default: begin
              state_d = S_EXC_EPC;
              cause_d = 2'd0;
            end
          endcase
        end else begin
          unique case (opcode)
            6'h08:        state_d = S_EXEC_I;
            6'h23, 6'h2b: state_d = S_MEM_ADDR;
            6'h04, 6'h05: state_d = S_BRANCH;
            6'h02:        state_d = S_JUMP;
            default: begin
              state_d = S_EXC_EPC;
              cause_d = 2'd0;
            end
          endcase
        end
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b111;
        state_d   = S_WB_R;
      end
      S_WB_R: begin
        reg_dst = 1'b1;
        if ((funct == 6'h20 || funct == 6'h22) && overflow) begin
          state_d = S_EXC_EPC;
          cause_d = 2'd1;
        end else begin
          reg_write = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_WB_I;
      end
      S_WB_I: begin
        if (overflow) begin
          state_d = S_EXC_EPC;
          cause_d = 2'd1;
        end else begin
          reg_write = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        cnt_d     = WAIT_LD;
        state_d   = (opcode == 6'h23) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        iord = 2'b01;
        if (cnt_q == '0) state_d = S_MEM_WB;
        else cnt_d = cnt_q - 1'b1;
      end
      S_MEM_WB: begin
        mem_to_reg = 2'b01;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        iord      = 2'b01;
        mem_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 3'b001;
        pc_source     = 2'b01;
        pc_write_cond = 1'b1;
        branch_ne     = (opcode == 6'h05);
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MD_START: begin
        md_start = 1'b1;
        md_op    = (funct == 6'h1a);
        state_d  = S_MD_WAIT;
      end
      S_MD_WAIT: begin
        if (md_done) begin
          if (md_div0) begin
            state_d = S_EXC_EPC;
            cause_d = 2'd2;
          end else begin
            hilo_write = 1'b1;
            state_d    = S_FETCH;
          end
        end
      end
      S_MF_WB: begin
        reg_dst    = 1'b1;
        mem_to_reg = (funct == 6'h10) ? 2'b10 : 2'b11;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXC_EPC: begin
        alu_src_b = 2'b01;
        alu_op    = 3'b001;
        epc_write = 1'b1;
        cnt_d     = WAIT_LD;
        state_d   = S_EXC_RD;
      end
      S_EXC_RD: begin
        iord = 2'b10;
        unique case (cause_q)
          2'd1:    exc_vec = 8'(VEC_OVF);
          2'd2:    exc_vec = 8'(VEC_DIV0);
          default: exc_vec = 8'(VEC_OPCODE);
        endcase
        if (cnt_q == '0) state_d = S_EXC_LOAD;
        else cnt_d = cnt_q - 1'b1;
      end
      S_EXC_LOAD: begin
        pc_source = 2'b11;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

  assign exc_cause    = cause_q;
  assign estado_saida = state_q;

endmodule

// File: tb/tb_unidade_controle_param.sv
// Scoreboard bench: per-cycle expected state/outputs queued
// ahead of each instruction, compared on the falling edge.
module tb_unidade_controle_param;

  localparam int MW = 3;

  localparam logic [31:0] M_RD    = 32'h0000001;
  localparam logic [31:0] PCW     = 32'h0000002;
  localparam logic [31:0] PCC     = 32'h0000004;
  localparam logic [31:0] BNE     = 32'h0000008;
  localparam logic [31:0] M_IORD  = 32'h0000030;
  localparam logic [31:0] MWR     = 32'h0000040;
  localparam logic [31:0] IR      = 32'h0000080;
  localparam logic [31:0] RW      = 32'h0000100;
  localparam logic [31:0] M_M2R   = 32'h0000600;
  localparam logic [31:0] EPC     = 32'h0000800;
  localparam logic [31:0] MDS     = 32'h0001000;
  localparam logic [31:0] M_MDOP  = 32'h0002000;
  localparam logic [31:0] HILO    = 32'h0004000;
  localparam logic [31:0] M_VEC   = 32'h07F8000;
  localparam logic [31:0] M_CAUSE = 32'h1800000;
  localparam logic [31:0] ALL     = 32'hFFFFFFFF;
  localparam logic [31:0] EN =
    PCW | PCC | MWR | IR | RW | EPC | MDS | HILO;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       overflow = 1'b0;
  logic       md_done = 1'b0;
  logic       md_div0 = 1'b0;

  logic       pc_write, pc_write_cond, branch_ne;
  logic [1:0] iord;
  logic [7:0] exc_vec;
  logic       mem_write, ir_write, reg_write, reg_dst;
  logic [1:0] mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic [1:0] pc_source;
  logic       epc_write, md_start, md_op, hilo_write;
  logic [1:0] exc_cause;
  logic [5:0] estado_saida;

  always #5 clk = ~clk;

  unidade_controle_param #(.MEM_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .zero(zero), .overflow(overflow), .md_done(md_done),
    .md_div0(md_div0), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
    .iord(iord), .exc_vec(exc_vec), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source),
    .epc_write(epc_write), .md_start(md_start), .md_op(md_op),
    .hilo_write(hilo_write), .exc_cause(exc_cause),
    .estado_saida(estado_saida)
  );

  logic [31:0] obs;
  assign obs = {7'd0, exc_cause, exc_vec, hilo_write, md_op,
                md_start, epc_write, mem_to_reg, reg_write,
                ir_write, mem_write, iord, branch_ne,
                pc_write_cond, pc_write, reg_dst};

  typedef struct {
    string       tag;
    logic [5:0]  st;
    logic [31:0] m;
    logic [31:0] v;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, want);
  endtask

  function automatic void push(input string tag,
                               input logic [5:0] st,
                               input logic [31:0] m,
                               input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.st  = st;
    e.m   = m | EN;
    e.v   = v;
    q.push_back(e);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check({e.tag, ".st"}, 32'(estado_saida), 32'(e.st));
      check({e.tag, ".out"}, obs & e.m, e.v);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    push("rst", 6'd0, ALL, 32'd0);
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
    push("rst", 6'd0, ALL, 32'd0);
    cyc(1);
  endtask

  function automatic void fetch_exp(input string tag);
    push(tag, 6'd1, M_IORD, 32'd0);
    for (int i = 0; i < MW - 1; i++) push(tag, 6'd2, 0, 0);
    push(tag, 6'd2, 0, IR | PCW);
    push(tag, 6'd3, 0, 0);
  endfunction

  function automatic void exc_exp(input string tag,
                                  input logic [1:0] cause,
                                  input logic [7:0] vec);
    logic [31:0] cv;
    cv = 32'(cause) << 23;
    push(tag, 6'd17, M_CAUSE, EPC | cv);
    for (int i = 0; i < MW; i++)
      push(tag, 6'd18, M_IORD | M_VEC | M_CAUSE,
           32'h20 | (32'(vec) << 15) | cv);
    push(tag, 6'd19, 0, PCW);
  endfunction

  task automatic md_test(input string tag, input logic [5:0] f,
                         input int n, input logic d0);
    opcode = 6'h00;
    funct  = f;
    fetch_exp(tag);
    push(tag, 6'd14, M_MDOP, MDS | (32'(f == 6'h1a) << 13));
    for (int i = 0; i < n - 1; i++) push(tag, 6'd15, 0, 0);
    push(tag, 6'd15, 0, d0 ? 32'd0 : HILO);
    if (d0) exc_exp(tag, 2'd2, 8'd255);
    cyc(5 + n);
    md_done = 1'b1;
    md_div0 = d0;
    cyc(1);
    md_done = 1'b0;
    md_div0 = 1'b0;
    if (d0) cyc(2 + MW);
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    opcode = 6'h23;
    fetch_exp("lw");
    push("lw", 6'd8, 0, 0);
    for (int i = 0; i < MW; i++) push("lw", 6'd9, M_IORD, 32'h10);
    push("lw", 6'd10, M_M2R | M_RD, 32'h200 | RW);
    cyc(10);

    opcode = 6'h00;
    funct  = 6'h20;
    fetch_exp("add");
    push("add", 6'd4, 0, 0);
    push("add", 6'd5, M_RD | M_M2R, M_RD | RW);
    cyc(7);

    overflow = 1'b1;
    fetch_exp("addovf");
    push("addovf", 6'd4, 0, 0);
    push("addovf", 6'd5, M_RD, M_RD);
    exc_exp("addovf", 2'd1, 8'd254);
    cyc(7 + MW + 2);
    overflow = 1'b0;

    opcode = 6'h3f;
    fetch_exp("badop");
    exc_exp("badop", 2'd0, 8'd253);
    cyc(5 + MW + 2);

    opcode = 6'h04;
    zero   = 1'b1;
    fetch_exp("beq");
    push("beq", 6'd12, BNE, PCC);
    cyc(6);

    opcode = 6'h05;
    zero   = 1'b0;
    fetch_exp("bne");
    push("bne", 6'd12, BNE, PCC | BNE);
    cyc(6);

    md_test("mult", 6'h18, 3, 1'b0);
    md_test("div0", 6'h1a, 32, 1'b1);
    md_test("div", 6'h1a, 32, 1'b0);

    opcode = 6'h00;
    funct  = 6'h1a;
    fetch_exp("mdrst");
    push("mdrst", 6'd14, M_MDOP, MDS | M_MDOP);
    for (int i = 0; i < 3; i++) push("mdrst", 6'd15, 0, 0);
    cyc(9);
    do_reset();

    funct = 6'h0d;
    fetch_exp("halt");
    for (int i = 0; i < 100; i++) push("halt", 6'd20, ALL, 0);
    cyc(105);

    check("drain", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
